// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and constants for the SPI boot loader
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, CMD, DATA, WRITE, CS_HOLD, DONE, ERROR
  } state_t;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;

  localparam logic [1:0] BOOT_SPI  = 2'd0;
  localparam logic [1:0] BOOT_SRAM = 2'd1;
  localparam logic [1:0] BOOT_DDR  = 2'd2;

  // Flash bytes arrive first-byte-in-MSB; memory wants first byte in [7:0].
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SPI mode-0 SCK generator with 32-bit MSB-first shifter
module spi_shift_engine #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic [31:0] tx_word,
  input  logic        miso,
  output logic        busy,
  output logic        done,
  output logic        sck,
  output logic        mosi,
  output logic [31:0] rx_word
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  logic [31:0]   tx_sr;
  logic          phase_end;

  assign phase_end = (div_cnt == DW'(CLK_DIV - 1));
  // Combinational so the owner can chain a new start onto the final falling edge.
  assign done = busy && !pause && sck && phase_end && (bit_cnt == 5'd31);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_word <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      sck     <= 1'b0;
      mosi    <= tx_word[31];
      tx_sr   <= {tx_word[30:0], 1'b0};
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (busy && !pause) begin
      if (!phase_end) begin
        div_cnt <= div_cnt + DW'(1);
      end else begin
        div_cnt <= '0;
        if (!sck) begin
          sck     <= 1'b1;
          rx_word <= {rx_word[30:0], miso};
        end else begin
          sck <= 1'b0;
          if (bit_cnt == 5'd31) begin
            busy <= 1'b0;
            mosi <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
            mosi    <= tx_sr[31];
            tx_sr   <= {tx_sr[30:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_boot_loader.sv
// rtl/spi_boot_loader.sv - boot sequencer: strap sampling, SPI flash image copy, CPU release
module spi_boot_loader
  import boot_pkg::*;
#(
  parameter int          CLK_DIV    = 1,
  parameter int          BOOT_WORDS = 1024,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter logic [31:0] MEM_BASE   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  boot_source_i,
  output logic        spi_sck_o,
  output logic        spi_cs_no,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i,
  output logic        wp_no,
  output logic        hold_no,
  output logic        mem_wr_valid_o,
  input  logic        mem_wr_ready_i,
  output logic [31:0] mem_wr_addr_o,
  output logic [31:0] mem_wr_data_o,
  output logic        cpu_rst_o,
  output logic        boot_done_o,
  output logic        boot_err_o
);

  localparam int IW = $clog2(BOOT_WORDS + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t        state, state_n;
  logic [IW-1:0] index;
  logic [DW-1:0] wait_cnt;
  logic          wait_end, last_word;
  logic          eng_start, eng_busy, eng_done;
  logic [31:0]   eng_tx, eng_rx;

  assign wait_end  = (wait_cnt == DW'(CLK_DIV - 1));
  assign last_word = (index == IW'(BOOT_WORDS - 1));
  assign wp_no     = 1'b1;
  assign hold_no   = 1'b1;

  spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk     (clk_i),
    .rst     (rst_i),
    .start   (eng_start),
    .pause   (state == WRITE),
    .tx_word (eng_tx),
    .miso    (spi_miso_i),
    .busy    (eng_busy),
    .done    (eng_done),
    .sck     (spi_sck_o),
    .mosi    (spi_mosi_o),
    .rx_word (eng_rx)
  );

  always_comb begin
    state_n   = state;
    eng_start = 1'b0;
    eng_tx    = '0;
    case (state)
      IDLE: begin
        case (boot_source_i)
          BOOT_SPI:            state_n = CS_SETUP;
          BOOT_SRAM, BOOT_DDR: state_n = DONE;
          default:             state_n = ERROR;
        endcase
      end
      CS_SETUP: begin
        if (wait_end && !eng_busy) begin
          state_n   = CMD;
          eng_start = 1'b1;
          eng_tx    = {SPI_CMD_READ, FLASH_BASE};
        end
      end
      CMD: begin
        if (eng_done) begin
          state_n   = DATA;
          eng_start = 1'b1;
        end
      end
      DATA: begin
        if (eng_done) state_n = WRITE;
      end
      WRITE: begin
        if (mem_wr_ready_i) begin
          if (last_word) begin
            state_n = CS_HOLD;
          end else begin
            state_n   = DATA;
            eng_start = 1'b1;
          end
        end
      end
      CS_HOLD: begin
        if (wait_end) state_n = DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      index          <= '0;
      wait_cnt       <= '0;
      spi_cs_no      <= 1'b1;
      mem_wr_valid_o <= 1'b0;
      mem_wr_addr_o  <= '0;
      mem_wr_data_o  <= '0;
      cpu_rst_o      <= 1'b1;
      boot_done_o    <= 1'b0;
      boot_err_o     <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= (state_n == state) ? wait_cnt + DW'(1) : '0;
      // CS follows the next state so it falls together with entry into CS_SETUP.
      spi_cs_no      <= !(state_n inside {CS_SETUP, CMD, DATA, WRITE, CS_HOLD});
      mem_wr_valid_o <= (state_n == WRITE);
      if (state == DATA && state_n == WRITE) begin
        mem_wr_addr_o <= MEM_BASE + (32'(index) << 2);
        mem_wr_data_o <= byte_swap(eng_rx);
      end
      if (state == WRITE && state_n == DATA) index <= index + IW'(1);
      cpu_rst_o   <= (state != DONE);
      boot_done_o <= (state == DONE);
      boot_err_o  <= (state == ERROR);
    end
  end

endmodule

// File: tb/tb_spi_boot_loader.sv
// tb/tb_spi_boot_loader.sv - self-checking bench with flash model and write scoreboard
module tb_spi_boot_loader;

  localparam int CD_A = 1;
  localparam int W_A  = 4;
  localparam int CD_B = 3;
  localparam int W_B  = 1;

  logic        clk, rst;
  logic [1:0]  source;
  logic        sck_a, cs_a, mosi_a, miso_a, wp_a, hold_a, valid_a, ready_a;
  logic        cpu_rst_a, done_a, err_a;
  logic [31:0] addr_a, data_a;
  logic        sck_b, cs_b, mosi_b, miso_b, wp_b, hold_b, valid_b;
  logic        cpu_rst_b, done_b, err_b;
  logic [31:0] addr_b, data_b;

  spi_boot_loader #(.CLK_DIV(CD_A), .BOOT_WORDS(W_A), .FLASH_BASE(24'h0), .MEM_BASE(32'h0)) dut_a (
    .clk_i(clk), .rst_i(rst), .boot_source_i(source),
    .spi_sck_o(sck_a), .spi_cs_no(cs_a), .spi_mosi_o(mosi_a), .spi_miso_i(miso_a),
    .wp_no(wp_a), .hold_no(hold_a),
    .mem_wr_valid_o(valid_a), .mem_wr_ready_i(ready_a),
    .mem_wr_addr_o(addr_a), .mem_wr_data_o(data_a),
    .cpu_rst_o(cpu_rst_a), .boot_done_o(done_a), .boot_err_o(err_a)
  );

  spi_boot_loader #(.CLK_DIV(CD_B), .BOOT_WORDS(W_B), .FLASH_BASE(24'h0), .MEM_BASE(32'h0)) dut_b (
    .clk_i(clk), .rst_i(rst), .boot_source_i(source),
    .spi_sck_o(sck_b), .spi_cs_no(cs_b), .spi_mosi_o(mosi_b), .spi_miso_i(miso_b),
    .wp_no(wp_b), .hold_no(hold_b),
    .mem_wr_valid_o(valid_b), .mem_wr_ready_i(1'b1),
    .mem_wr_addr_o(addr_b), .mem_wr_data_o(data_b),
    .cpu_rst_o(cpu_rst_b), .boot_done_o(done_b), .boot_err_o(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Flash: a byte array served by READ from the address in the command.
  logic [7:0]  flash_mem [256];
  logic [31:0] cmd_a, cmd_b;
  int          cnt_a = 0, cnt_b = 0;

  function automatic logic flash_bit(input logic [31:0] cmd, input int n);
    int d;
    logic [7:0] b;
    if (n < 32) return 1'b0;
    d = n - 32;
    b = flash_mem[cmd[7:0] + 8'(d / 8)];
    return b[7 - (d % 8)];
  endfunction

  initial begin miso_a = 1'b0; miso_b = 1'b0; cmd_a = '0; cmd_b = '0; end

  always @(posedge sck_a or posedge cs_a)
    if (cs_a) cnt_a <= 0;
    else begin
      if (cnt_a < 32) cmd_a <= {cmd_a[30:0], mosi_a};
      cnt_a <= cnt_a + 1;
    end
  always @(negedge sck_a) miso_a <= flash_bit(cmd_a, cnt_a);

  always @(posedge sck_b or posedge cs_b)
    if (cs_b) cnt_b <= 0;
    else begin
      if (cnt_b < 32) cmd_b <= {cmd_b[30:0], mosi_b};
      cnt_b <= cnt_b + 1;
    end
  always @(negedge sck_b) miso_b <= flash_bit(cmd_b, cnt_b);

  // Reference: expected writes, cycle count since release, stall accounting.
  logic [63:0] exp_q [$];
  logic [1:0]  cur_src = 2'd1;
  int          cyc = 0;
  int          stalls = 0, wr_seen = 0;
  int          done_cyc_a = -1, done_cyc_b = -1;
  int          ready_mode = 0, stall_left = 0;
  bit          b_active = 0;

  function automatic logic [31:0] image_word(input int i);
    return {flash_mem[4*i+3], flash_mem[4*i+2], flash_mem[4*i+1], flash_mem[4*i]};
  endfunction

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  initial begin
    ready_a = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        1: if (valid_a && wr_seen == 2 && stall_left > 0) begin ready_a = 1'b0; stall_left--; end
           else ready_a = 1'b1;
        2: ready_a = 1'($urandom_range(0, 1));
        default: ready_a = 1'b1;
      endcase
    end
  end

  bit          done_a_prev, done_b_prev, held, sck_b_prev, b_seen_high;
  logic [31:0] held_addr, held_data;
  int          run_b;
  logic [63:0] exp_wr;

  always @(negedge clk) begin
    if (rst) begin
      done_a_prev = 0; done_b_prev = 0; held = 0;
      sck_b_prev = 0; b_seen_high = 0; run_b = 0;
    end else begin
      check("wp_hold", {wp_a, hold_a, wp_b, hold_b}, 4'hF);
      check("cpu_rst_vs_done", cpu_rst_a, !done_a);
      if (cur_src != 2'd0) begin
        check("spi_idle", {cs_a, sck_a, mosi_a, valid_a}, 4'b1000);
        check("err_flag", err_a, (cur_src == 2'd3 && cyc >= 2));
      end
      if (valid_a) begin
        check("stall_bus", {cs_a, sck_a}, 2'b00);
        if (held) check("stall_stable", {addr_a, data_a}, {held_addr, held_data});
        if (ready_a) begin
          held = 0;
          wr_seen++;
          if (exp_q.size() == 0) check("unexpected_write", {addr_a, data_a}, 64'h0);
          else begin
            exp_wr = exp_q.pop_front();
            check("write", {addr_a, data_a}, exp_wr);
          end
        end else begin
          stalls++;
          held = 1;
          held_addr = addr_a;
          held_data = data_a;
        end
      end
      if (done_a && !done_a_prev) begin
        done_cyc_a = cyc;
        if (cur_src == 2'd0) begin
          check("done_cycle", cyc, 2 + 2*CD_A + 64*CD_A*(W_A+1) + W_A + stalls);
          check("writes_left", exp_q.size(), 0);
          check("read_cmd", cmd_a, 32'h0300_0000);
        end else begin
          check("done_cycle", cyc, 2);
        end
      end
      done_a_prev = done_a;
      if (b_active) begin
        if (valid_b) check("b_write", {addr_b, data_b}, {32'h0, image_word(0)});
        if (sck_b != sck_b_prev) begin
          if (sck_b_prev || b_seen_high) check("b_sck_phase", run_b, CD_B);
          if (sck_b_prev) b_seen_high = 1;
          run_b = 1;
        end else run_b++;
      end
      if (cs_b) b_seen_high = 0;
      sck_b_prev = sck_b;
      if (done_b && !done_b_prev) done_cyc_b = cyc;
      done_b_prev = done_b;
    end
  end

  task automatic load_model();
    exp_q.delete();
    for (int i = 0; i < W_A; i++) exp_q.push_back({32'(4*i), image_word(i)});
    stalls = 0;
    wr_seen = 0;
    stall_left = 7;
    done_cyc_a = -1;
    done_cyc_b = -1;
  endtask

  task automatic start_run(input logic [1:0] src, input int mode, input bit b_on);
    @(posedge clk);
    #2;
    rst = 1'b1;
    source = src;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {sck_a, cs_a, mosi_a, valid_a, cpu_rst_a, done_a, err_a}, 7'b0100100);
    check("reset_bus", {addr_a, data_a}, 64'h0);
    cur_src = src;
    ready_mode = mode;
    b_active = b_on;
    load_model();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit use_b, input int budget);
    int i = 0;
    while (!(use_b ? done_b : done_a) && i < budget) begin @(negedge clk); i++; end
    if (!(use_b ? done_b : done_a)) begin
      checks++;
      errors++;
      $display("FAIL %s: boot_done_o still low after %0d cycles", name, budget);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    source = 2'd1;
    for (int i = 0; i < 256; i++) flash_mem[i] = 8'(i);

    // SRAM strap: release two edges after reset, no SPI traffic.
    start_run(2'd1, 0, 0);
    wait_done("sram_boot", 0, 50);
    check("sram_done_lit", done_cyc_a, 2);
    repeat (20) @(negedge clk);

    // DDR strap, same behaviour.
    start_run(2'd2, 0, 0);
    wait_done("ddr_boot", 0, 50);
    check("ddr_done_lit", done_cyc_a, 2);

    // SPI boot of bytes 00..0F; literal pins of the model.
    start_run(2'd0, 0, 1);
    check("model_word0", exp_q[0], {32'h0, 32'h0302_0100});
    check("model_word3", exp_q[3], {32'hC, 32'h0F0E_0D0C});
    wait_done("spi_boot", 0, 2000);
    check("spi_done_lit", done_cyc_a, 328);
    wait_done("spi_boot_div3", 1, 2000);
    check("div3_done_lit", done_cyc_b, 393);
    check("div3_cmd", cmd_b, 32'h0300_0000);

    // Same image, ready held low 7 cycles on word 2.
    start_run(2'd0, 1, 0);
    wait_done("spi_stall", 0, 2000);
    check("stall_done_lit", done_cyc_a, 335);
    check("stall_count", stalls, 7);

    // Random image, random ready.
    for (int i = 0; i < 256; i++) flash_mem[i] = 8'($urandom);
    start_run(2'd0, 2, 0);
    wait_done("spi_random", 0, 4000);

    // Reserved strap: error, CPU held in reset.
    start_run(2'd3, 0, 0);
    repeat (1000) @(negedge clk);
    check("reserved_final", {err_a, cpu_rst_a, done_a, cs_a}, 4'b1101);

    // Reset pulse during word 2 data, then full rerun.
    start_run(2'd0, 0, 0);
    for (int i = 0; i < 1000 && wr_seen < 2; i++) @(negedge clk);
    check("reached_word2", wr_seen, 2);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_outputs", {cs_a, valid_a, sck_a, cpu_rst_a}, 4'b1001);
    load_model();
    @(posedge clk);
    #2;
    rst = 1'b0;
    wait_done("spi_rerun", 0, 2000);
    check("rerun_done_lit", done_cyc_a, 328);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
